// File: rtl/axi4_slave_bfm_if.sv
// AXI4 bus bundle between a master and axi4_slave_bfm.
// Widths follow the same parameters as the BFM.
interface axi4_slave_bfm_if #(
  parameter int DATA_BYTES      = 4,
  parameter int ADDR_BYTES      = 1,
  parameter int NUM_ID_BITS_P   = 4,
  parameter int NUM_USER_BITS_P = 4
);
  localparam int DW = 8*DATA_BYTES;
  localparam int AW = 8*ADDR_BYTES;

  logic                       awvalid, awready;
  logic [AW-1:0]              awaddr;
  logic [NUM_ID_BITS_P-1:0]   awid;
  logic [7:0]                 awlen;
  logic [2:0]                 awsize;
  logic [1:0]                 awburst;
  logic [3:0]                 awcache;
  logic [2:0]                 awprot;
  logic                       awlock;
  logic [3:0]                 awregion;
  logic [3:0]                 awqos;
  logic [NUM_USER_BITS_P-1:0] awuser;

  logic                       wvalid, wready;
  logic [DW-1:0]              wdata;
  logic [DATA_BYTES-1:0]      wstrb;
  logic                       wlast;
  logic [NUM_USER_BITS_P-1:0] wuser;

  logic                       bwvalid, bwready;
  logic [1:0]                 bresp;
  logic [NUM_ID_BITS_P-1:0]   bid;
  logic [NUM_USER_BITS_P-1:0] buser;

  logic                       arvalid, aready;
  logic [AW-1:0]              araddr;
  logic [NUM_ID_BITS_P-1:0]   arid;
  logic [7:0]                 arlen;
  logic [2:0]                 arsize;
  logic [1:0]                 arburst;
  logic [3:0]                 arcache;
  logic [2:0]                 arprot;
  logic                       arlock;
  logic [3:0]                 arregion;
  logic [3:0]                 arqos;
  logic [NUM_USER_BITS_P-1:0] aruser;

  logic                       rvalid, rready;
  logic [DW-1:0]              rdata;
  logic [1:0]                 rresp;
  logic [NUM_ID_BITS_P-1:0]   rid;
  logic                       rlast;
  logic [NUM_USER_BITS_P-1:0] ruser;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, awcache, awprot,
           awlock, awregion, awqos, awuser,
           wvalid, wdata, wstrb, wlast, wuser, bwready,
           arvalid, araddr, arid, arlen, arsize, arburst, arcache, arprot,
           arlock, arregion, arqos, aruser, rready,
    output awready, wready, bwvalid, bresp, bid, buser,
           aready, rvalid, rdata, rresp, rid, rlast, ruser
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, awcache, awprot,
           awlock, awregion, awqos, awuser,
           wvalid, wdata, wstrb, wlast, wuser, bwready,
           arvalid, araddr, arid, arlen, arsize, arburst, arcache, arprot,
           arlock, arregion, arqos, aruser, rready,
    input  awready, wready, bwvalid, bresp, bid, buser,
           aready, rvalid, rdata, rresp, rid, rlast, ruser
  );
endinterface

// File: rtl/axi4_slave_bfm.sv
// AXI4 slave memory model: independent write/read FSMs over a 2^AW-byte array.
// Define AXI4_SLAVE_BFM_WSTRB_EN to honour wstrb; otherwise every beat writes the full word.
module axi4_slave_bfm #(
  parameter int    DATA_BYTES      = 4,
  parameter int    ADDR_BYTES      = 1,
  parameter int    NUM_ID_BITS_P   = 4,
  parameter int    NUM_USER_BITS_P = 4,
  parameter string BFM_NAME        = "axi4_slv"
) (
  input logic             aclk,
  input logic             areset,
  axi4_slave_bfm_if.slave bus
);
  localparam int DW  = 8*DATA_BYTES;
  localparam int AW  = 8*ADDR_BYTES;
  localparam int LB  = $clog2(DATA_BYTES);
  localparam int IW  = AW - LB;
  localparam int NW  = 1 << IW;
  localparam int IDW = NUM_ID_BITS_P;

  localparam string unused_name = BFM_NAME;
  localparam int    unused_ub   = NUM_USER_BITS_P;

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wst_t;
  typedef enum logic       {RIDLE, RDATA}        rst_t;

  // Oversized beats and WRAP/reserved bursts are answered with SLVERR.
  function automatic logic illegal(input logic [2:0] size, input logic [1:0] burst);
    return (size > 3'(LB)) || burst[1];
  endfunction

  function automatic logic [AW-1:0] nxt_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
    return (burst == 2'b01) ? a + (AW'(1) << size) : a;
  endfunction

  logic [DW-1:0] mem [NW];

  // ---------------- write channel ----------------
  wst_t            wst, wst_nxt;
  logic [AW-1:0]   waddr;
  logic [IDW-1:0]  wid_q;
  logic [7:0]      wlen, wcnt;
  logic [2:0]      wsize;
  logic [1:0]      wburst;
  logic            werr, w_ill, w_last_beat;
  logic            aw_rdy, w_rdy, b_vld, aw_hs, w_hs;
  logic [DATA_BYTES-1:0] lane_we;

  assign w_ill       = illegal(wsize, wburst);
  assign w_last_beat = (wcnt == wlen);
  assign aw_hs       = bus.awvalid && aw_rdy;
  assign w_hs        = bus.wvalid && w_rdy;

  always_ff @(posedge aclk)
    if (areset) wst <= WIDLE;
    else        wst <= wst_nxt;

  always_comb begin
    wst_nxt = wst;
    aw_rdy  = 1'b0;
    w_rdy   = 1'b0;
    b_vld   = 1'b0;
    if (!areset) begin
      case (wst)
        WIDLE: begin aw_rdy = 1'b1; if (bus.awvalid) wst_nxt = WDATA; end
        WDATA: begin w_rdy = 1'b1; if (bus.wvalid && w_last_beat) wst_nxt = WRESP; end
        WRESP: begin b_vld = 1'b1; if (bus.bwready) wst_nxt = WIDLE; end
        default: wst_nxt = WIDLE;
      endcase
    end
  end

  // The beat count, not wlast, ends the burst; wlast only feeds the error flag.
  always_ff @(posedge aclk)
    if (areset) begin
      waddr  <= '0;
      wid_q  <= '0;
      wlen   <= '0;
      wsize  <= '0;
      wburst <= '0;
      wcnt   <= '0;
      werr   <= 1'b0;
    end else if (aw_hs) begin
      waddr  <= bus.awaddr;
      wid_q  <= bus.awid;
      wlen   <= bus.awlen;
      wsize  <= bus.awsize;
      wburst <= bus.awburst;
      wcnt   <= '0;
      werr   <= 1'b0;
    end else if (w_hs) begin
      waddr <= nxt_addr(waddr, wsize, wburst);
      wcnt  <= wcnt + 8'd1;
      if (bus.wlast != w_last_beat) werr <= 1'b1;
    end

`ifdef AXI4_SLAVE_BFM_WSTRB_EN
  assign lane_we = bus.wstrb;
`else
  assign lane_we = '1;
`endif

  always_ff @(posedge aclk)
    if (areset) begin
      for (int i = 0; i < NW; i++) mem[i] <= '0;
    end else if (w_hs && !w_ill) begin
      for (int b = 0; b < DATA_BYTES; b++)
        if (lane_we[b]) mem[waddr[AW-1:LB]][8*b +: 8] <= bus.wdata[8*b +: 8];
    end

  assign bus.awready = aw_rdy;
  assign bus.wready  = w_rdy;
  assign bus.bwvalid = b_vld;
  assign bus.bresp   = (b_vld && (werr || w_ill)) ? 2'b10 : 2'b00;
  assign bus.bid     = b_vld ? wid_q : '0;
  assign bus.buser   = '0;

  // ---------------- read channel ----------------
  rst_t            rst, rst_nxt;
  logic [AW-1:0]   raddr;
  logic [IDW-1:0]  rid_q;
  logic [7:0]      rlen, rcnt;
  logic [2:0]      rsize;
  logic [1:0]      rburst;
  logic            r_ill, r_last_beat, ar_rdy, r_vld, ar_hs, r_hs;

  assign r_ill       = illegal(rsize, rburst);
  assign r_last_beat = (rcnt == rlen);
  assign ar_hs       = bus.arvalid && ar_rdy;
  assign r_hs        = r_vld && bus.rready;

  always_ff @(posedge aclk)
    if (areset) rst <= RIDLE;
    else        rst <= rst_nxt;

  always_comb begin
    rst_nxt = rst;
    ar_rdy  = 1'b0;
    r_vld   = 1'b0;
    if (!areset) begin
      case (rst)
        RIDLE: begin ar_rdy = 1'b1; if (bus.arvalid) rst_nxt = RDATA; end
        RDATA: begin r_vld = 1'b1; if (bus.rready && r_last_beat) rst_nxt = RIDLE; end
        default: rst_nxt = RIDLE;
      endcase
    end
  end

  always_ff @(posedge aclk)
    if (areset) begin
      raddr  <= '0;
      rid_q  <= '0;
      rlen   <= '0;
      rsize  <= '0;
      rburst <= '0;
      rcnt   <= '0;
    end else if (ar_hs) begin
      raddr  <= bus.araddr;
      rid_q  <= bus.arid;
      rlen   <= bus.arlen;
      rsize  <= bus.arsize;
      rburst <= bus.arburst;
      rcnt   <= '0;
    end else if (r_hs) begin
      raddr <= nxt_addr(raddr, rsize, rburst);
      rcnt  <= rcnt + 8'd1;
    end

  // Combinational read: a same-cycle write lands after this beat's data is taken.
  assign bus.aready = ar_rdy;
  assign bus.rvalid = r_vld;
  assign bus.rdata  = (r_vld && !r_ill) ? mem[raddr[AW-1:LB]] : '0;
  assign bus.rresp  = (r_vld && r_ill) ? 2'b10 : 2'b00;
  assign bus.rid    = r_vld ? rid_q : '0;
  assign bus.rlast  = r_vld && r_last_beat;
  assign bus.ruser  = '0;

  logic unused_ok;
  assign unused_ok = ^{bus.awcache, bus.awprot, bus.awlock, bus.awregion, bus.awqos, bus.awuser,
                       bus.wuser, bus.wstrb, bus.arcache, bus.arprot, bus.arlock, bus.arregion,
                       bus.arqos, bus.aruser};
endmodule

// File: tb/tb_axi4_slave_bfm.sv
// Scoreboard bench for axi4_slave_bfm: expected B/R responses are queued at issue
// and popped when the BFM responds; a byte-array model tracks memory contents.
module tb_axi4_slave_bfm;
  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_slave_bfm_if bus();
  axi4_slave_bfm dut (.aclk(aclk), .areset(areset), .bus(bus));

  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
  typedef struct { logic [31:0] d; logic [1:0] resp; logic [3:0] id; logic last; } rexp_t;

  localparam int TMO = 50;
  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] mdl [64];
  bexp_t       bq [$];
  rexp_t       rq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  function automatic logic [7:0] adv(input logic [7:0] a, input logic [2:0] sz, input logic [1:0] bu);
    if (bu == 2'b01) return a + (8'd1 << sz);
    return a;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    repeat (10) tick();
    chk("rst_awready", bus.awready, 0);
    chk("rst_aready",  bus.aready,  0);
    areset = 1'b0;
    #1;
    chk("rel_awready", bus.awready, 1);
    chk("rel_aready",  bus.aready,  1);
    chk("rel_bwvalid", bus.bwvalid, 0);
    chk("rel_rvalid",  bus.rvalid,  0);
    chk("rel_wready",  bus.wready,  0);
    for (int i = 0; i < 64; i++) mdl[i] = '0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [3:0] id, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                    input logic [3:0] strb, input bit bad_last);
    bexp_t e;
    logic [7:0] a;
    logic [31:0] dat;
    int n;
    logic ill;
    ill    = (size > 3'd2) || burst[1];
    e.resp = (ill || bad_last) ? 2'b10 : 2'b00;
    e.id   = id;
    bq.push_back(e);
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id; bus.awlen = len;
    bus.awsize = size; bus.awburst = burst;
    n = 0;
    while (!bus.awready && n < TMO) begin tick(); n++; end
    chk("awready", bus.awready, 1);
    tick();
    bus.awvalid = 1'b0;
    chk("wready_lat", bus.wready, 1);
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      dat = d0 + k;
      bus.wvalid = 1'b1; bus.wdata = dat; bus.wstrb = strb;
      bus.wlast  = (k == int'(len)) && !bad_last;
      n = 0;
      while (!bus.wready && n < TMO) begin tick(); n++; end
      chk("wready", bus.wready, 1);
      tick();
      if (!ill)
        for (int b = 0; b < 4; b++) begin
`ifdef AXI4_SLAVE_BFM_WSTRB_EN
          if (strb[b]) mdl[a[7:2]][8*b +: 8] = dat[8*b +: 8];
`else
          mdl[a[7:2]][8*b +: 8] = dat[8*b +: 8];
`endif
        end
      a = adv(a, size, burst);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("bvalid_lat", bus.bwvalid, 1);
    e = bq.pop_front();
    chk("bresp", bus.bresp, e.resp);
    chk("bid",   bus.bid,   e.id);
    bus.bwready = 1'b1;
    tick();
    bus.bwready = 1'b0;
    chk("awready_after_b", bus.awready, 1);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [3:0] id, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input bit stall);
    rexp_t e;
    logic [7:0] a;
    int n;
    logic ill;
    ill = (size > 3'd2) || burst[1];
    a = addr;
    for (int k = 0; k <= int'(len); k++) begin
      e.d    = ill ? 32'h0 : mdl[a[7:2]];
      e.resp = ill ? 2'b10 : 2'b00;
      e.id   = id;
      e.last = (k == int'(len));
      rq.push_back(e);
      a = adv(a, size, burst);
    end
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id; bus.arlen = len;
    bus.arsize = size; bus.arburst = burst;
    n = 0;
    while (!bus.aready && n < TMO) begin tick(); n++; end
    chk("aready", bus.aready, 1);
    tick();
    bus.arvalid = 1'b0;
    chk("rvalid_lat", bus.rvalid, 1);
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      while (!bus.rvalid && n < TMO) begin tick(); n++; end
      chk("rvalid", bus.rvalid, 1);
      e = rq.pop_front();
      chk("rdata", bus.rdata, e.d);
      chk("rresp", bus.rresp, e.resp);
      chk("rid",   bus.rid,   e.id);
      chk("rlast", bus.rlast, e.last);
      if (stall) begin
        bus.rready = 1'b0;
        tick();
        chk("rvalid_hold", bus.rvalid, 1);
        chk("rdata_hold",  bus.rdata,  e.d);
        chk("rlast_hold",  bus.rlast,  e.last);
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
    end
    chk("aready_after_r", bus.aready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0;
    bus.awburst = 0; bus.awcache = 0; bus.awprot = 0; bus.awlock = 0; bus.awregion = 0;
    bus.awqos = 0; bus.awuser = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wuser = 0;
    bus.bwready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0;
    bus.arburst = 0; bus.arcache = 0; bus.arprot = 0; bus.arlock = 0; bus.arregion = 0;
    bus.arqos = 0; bus.aruser = 0;
    bus.rready = 0;

    do_reset();
    rd(8'h00, 4'h1, 8'd0, 3'd2, 2'b01, 1'b0);
    wr(8'hFF, 4'h5, 8'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF, 1'b0);
    rd(8'hFF, 4'h2, 8'd0, 3'd2, 2'b01, 1'b0);

    // leave a write mid-burst, then reset must abort it without a response
    bus.awvalid = 1'b1; bus.awaddr = 8'h08; bus.awlen = 8'd2; bus.awsize = 3'd2; bus.awburst = 2'b01;
    tick();
    bus.awvalid = 1'b0;
    chk("abort_wready", bus.wready, 1);
    do_reset();

    // write and read of the same word launched together; read sees pre-write data
    fork
      wr(8'hFF, 4'h3, 8'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd(8'hFF, 4'h9, 8'd0, 3'd2, 2'b01, 1'b0);
    join
    rd(8'hFF, 4'h4, 8'd0, 3'd2, 2'b01, 1'b0);

    wr(8'hF8, 4'h7, 8'd3, 3'd2, 2'b01, 32'd1, 4'hF, 1'b0);
    rd(8'hF8, 4'h8, 8'd3, 3'd2, 2'b01, 1'b1);

    wr(8'h10, 4'h1, 8'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wr(8'h10, 4'h2, 8'd0, 3'd2, 2'b01, 32'hAABB_CCDD, 4'h3, 1'b0);
    rd(8'h10, 4'h3, 8'd0, 3'd2, 2'b01, 1'b0);

    wr(8'h20, 4'hC, 8'd0, 3'd2, 2'b10, 32'h1234_5678, 4'hF, 1'b0);
    rd(8'h20, 4'hD, 8'd0, 3'd2, 2'b01, 1'b0);
    wr(8'h24, 4'hE, 8'd1, 3'd2, 2'b11, 32'h0000_00A0, 4'hF, 1'b0);
    rd(8'h10, 4'hF, 8'd1, 3'd3, 2'b01, 1'b0);

    wr(8'h30, 4'hA, 8'd1, 3'd2, 2'b01, 32'h0000_0055, 4'hF, 1'b1);
    rd(8'h30, 4'hB, 8'd1, 3'd2, 2'b01, 1'b0);

    wr(8'h40, 4'h6, 8'd2, 3'd2, 2'b00, 32'd7, 4'hF, 1'b0);
    rd(8'h40, 4'h5, 8'd1, 3'd2, 2'b00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_slave_bfm.md
AXI4_SLAVE_BFM -- requirements
Module: axi4_slave_bfm

Interface
REQ-001 Parameters:
- DATA_BYTES=4: data bus bytes, power of 2.
- ADDR_BYTES=1: address bytes.
- NUM_ID_BITS_P=4 and NUM_USER_BITS_P=4.
- BFM_NAME="axi4_slv": simulation message prefix only, no logic effect.
- Derived: DW=8*DATA_BYTES, AW=8*ADDR_BYTES.
REQ-002 aclk  in  1  -- sole clock; all state changes on the rising edge.
REQ-003 areset  in  1  -- reset, synchronous and active-high.
REQ-004 awvalid in 1, awready out 1, awaddr in AW, awid in ID, awlen in 8, awsize in 3, awburst in 2  -- write address.
REQ-005 awcache in 4, awprot in 3, awlock in 1, awregion in 4, awqos in 4, awuser in USER  -- accepted, ignored.
REQ-006 wvalid in 1, wready out 1, wdata in DW, wstrb in DATA_BYTES, wlast in 1, wuser in USER (ignored)  -- write data.
REQ-007 bwvalid out 1, bwready in 1, bresp out 2, bid out ID, buser out USER (tied 0)  -- write response.
REQ-008 arvalid in 1, aready out 1, araddr in AW, arid in ID, arlen in 8, arsize in 3, arburst in 2; arcache/arprot/arlock/arregion/arqos/aruser in, ignored  -- read address.
REQ-009 rvalid out 1, rready in 1, rdata out DW, rresp out 2, rid out ID, rlast out 1, ruser out USER (tied 0)  -- read data.

Function
REQ-010 Storage: 2^AW/DATA_BYTES words of DW bits (64x32 default); word index = addr[AW-1:log2(DATA_BYTES)].
REQ-011 Write FSM WIDLE->WDATA->WRESP->WIDLE:
- awready=1 only in WIDLE.
- wready=1 only in WDATA.
- bwvalid=1 only in WRESP.
REQ-012 AW handshake latches awaddr/awid/awlen/awsize/awburst, clears the beat count, and enters WDATA next cycle.
REQ-013 Each W handshake:
- Writes the current word (lanes per REQ-027), advances the address, counts the beat.
- Handshake of beat awlen+1 enters WRESP next cycle, regardless of wlast.
REQ-014 bresp and bid:
- bresp=OKAY(00) normally.
- bresp=SLVERR(10) if wlast mismatches on any beat, if awsize>log2(DATA_BYTES), or if awburst is WRAP(10) or reserved(11).
- Illegal size/burst still consumes all beats but writes nothing; a wlast mismatch alone still writes.
- bid=latched awid.
REQ-015 bwvalid holds until bwready; the handshake returns to WIDLE, with awready=1 the next cycle.
REQ-016 Read FSM RIDLE->RDATA->RIDLE; aready=1 only in RIDLE; rvalid=1 only in RDATA.
REQ-017 AR handshake latches ar* fields and enters RDATA next cycle; rdata combinationally reflects the current word, giving 1 beat/clk while rready=1.
REQ-018 Read response fields:
- rlast=1 only on beat arlen+1; rid=latched arid.
- Illegal arsize/arburst (REQ-014 rules): rresp=SLVERR, rdata=0 on all beats; otherwise rresp=OKAY.
- Last-beat handshake returns to RIDLE.
REQ-019 rvalid/rdata/rlast/rresp/rid stay stable while rvalid=1 and rready=0.
REQ-020 Address advance: FIXED(00) unchanged; INCR(01) addr += 2^size modulo 2^AW (0xFC+4 -> 0x00).
REQ-021 Read and write channels are independent and concurrent.
- A W handshake coinciding with a read beat to the same word returns pre-write data on that beat.
- The new data is visible from the next cycle.
REQ-022 Latency:
- AW handshake at cycle N -> wready at N+1.
- Last W handshake at M -> bwvalid at M+1.
- AR handshake at N -> first rvalid at N+1.
REQ-023 One outstanding transaction per direction; in-order; IDs echoed unchanged.

Reset
REQ-024 areset=1 at a rising edge: both FSMs go to IDLE, all memory words and latched fields clear to 0.
REQ-025 While areset=1, all outputs are 0, including awready and aready; awready=aready=1 from the first cycle after release.
REQ-026 Reset mid-transaction aborts it; no response is issued.

Configuration
REQ-027 Macro AXI4_SLAVE_BFM_WSTRB_EN:
- Defined: only byte lanes with wstrb[i]=1 are written.
- Undefined: wstrb is ignored and the full word is written on every beat.

Verification
REQ-028 Reset 10 cycles, release -> awready=aready=1, bwvalid=rvalid=0; read 0x00 len0 -> rdata=0, rresp=00, rlast=1.
REQ-029 Write awaddr=0xFF len0 size2 INCR wdata=0xFFFFFFFF wstrb=0xF wlast=1 -> bwvalid one cycle after W handshake, bresp=00, bid=awid; read 0xFF -> rdata=0xFFFFFFFF, rlast=1.
REQ-030 Write and read to 0xFF launched the same cycle after reset, with the W handshake coinciding with the first read beat -> both complete; read returns 0x00000000.
REQ-031 INCR write awaddr=0xF8 len3 data 1,2,3,4 -> words 0xF8,0xFC,0x00,0x04 (wrap); readback of 4 beats with rready toggled 1/0 -> data held stable while stalled, rlast on 4th beat only.
REQ-032 Over 0xFFFFFFFF, write 0xAABBCCDD with wstrb=0x3 -> reads 0xFFFFCCDD with macro, 0xAABBCCDD without.
REQ-033 awburst=WRAP -> bresp=10 and memory unchanged; arsize=3 -> rresp=10, rdata=0.
